led_sopc_nios2_qsys_oci_dct_packer: RTL and testbench



---
 rtl/led_sopc_nios2_qsys_oci_dct_pkg.sv | 21 ++
 rtl/led_sopc_nios2_qsys_oci_dct_frame_reg.sv | 43 ++++
 rtl/led_sopc_nios2_qsys_oci_dct_packer.sv | 124 ++++++++++++
 tb/tb_led_sopc_nios2_qsys_oci_dct_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sopc_nios2_qsys_oci_dct_pkg.sv
// rtl/led_sopc_nios2_qsys_oci_dct_pkg.sv - shared sizes, frame type and FSM states for the DCT packer
package led_sopc_nios2_qsys_oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = ATOM_W * SLOTS;
    localparam int CNT_W  = 4;

    // One emitted frame: atom count above the packed atom buffer.
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [BUF_W-1:0] buffer;
    } frame_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/led_sopc_nios2_qsys_oci_dct_frame_reg.sv
// rtl/led_sopc_nios2_qsys_oci_dct_frame_reg.sv - single-entry frame output register with valid/ready
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          write load_frame_i into the entry (caller guarantees free_o)
//   load_frame_i    frame to store
//   ready_i         consumer accepts the frame when valid_o & ready_i
//   valid_o         entry holds a frame
//   frame_o         stored frame, stable while valid_o and not accepted
//   free_o          entry can take a load this cycle (empty or draining now)
module led_sopc_nios2_qsys_oci_dct_frame_reg
    import led_sopc_nios2_qsys_oci_dct_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  frame_t load_frame_i,
    input  logic   ready_i,
    output logic   valid_o,
    output frame_t frame_o,
    output logic   free_o
);

    logic   valid_q;
    frame_t frame_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            frame_q <= '0;
        end else if (load_i) begin
            // A load on the accept cycle replaces the departing frame back-to-back.
            valid_q <= 1'b1;
            frame_q <= load_frame_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign frame_o = frame_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/led_sopc_nios2_qsys_oci_dct_packer.sv
// rtl/led_sopc_nios2_qsys_oci_dct_packer.sv - packs 2-bit trace atoms into 15-atom DCT frames
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   atom_valid/atom_data      offered trace atom; atom_ready accepts it
//   test_ending               one-cycle request to flush the partial frame
//   test_has_ended            level, session over; enter DONE once drained
//   frm_valid/frm_ready       frame handshake toward the trace FIFO
//   dct_buffer/dct_count      frame payload (oldest atom highest) and atom count
//   dct_done                  session fully drained
module led_sopc_nios2_qsys_oci_dct_packer
    import led_sopc_nios2_qsys_oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    output logic              atom_ready,
    input  logic              test_ending,
    input  logic              test_has_ended,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              dct_done
);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   fill_buf_q, fill_buf_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic               flush_pend_q, flush_pend_d;

    logic               accept;
    logic [BUF_W-1:0]   buf_a;
    logic [CNT_W-1:0]   cnt_a;
    logic               load;
    frame_t             load_frame;
    frame_t             frame;
    logic               slot_free;

    assign atom_ready = (state_q == FILL);
    assign dct_done   = (state_q == DONE);
    assign accept     = atom_valid && atom_ready;

    // Fill contents including any atom accepted this cycle, so a flush or
    // 15th atom in this cycle sees the complete frame.
    assign buf_a = accept ? {fill_buf_q[BUF_W-ATOM_W-1:0], atom_data} : fill_buf_q;
    assign cnt_a = accept ? fill_cnt_q + CNT_W'(1) : fill_cnt_q;

    always_comb begin
        state_d      = state_q;
        fill_buf_d   = fill_buf_q;
        fill_cnt_d   = fill_cnt_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;
        load_frame   = '0;
        case (state_q)
            FILL: begin
                fill_buf_d = buf_a;
                fill_cnt_d = cnt_a;
                if (cnt_a == CNT_W'(SLOTS) || (test_ending && cnt_a != '0)) begin
                    if (slot_free) begin
                        load       = 1'b1;
                        load_frame = {cnt_a, buf_a};
                        fill_buf_d = '0;
                        fill_cnt_d = '0;
                    end else begin
                        state_d      = HOLD;
                        flush_pend_d = test_ending;
                    end
                end else if (test_has_ended && cnt_a == '0 && !frm_valid && !flush_pend_q) begin
                    state_d = DONE;
                end
            end
            HOLD: begin
                if (test_ending) begin
                    flush_pend_d = 1'b1;
                end
                if (slot_free) begin
                    load         = 1'b1;
                    load_frame   = {fill_cnt_q, fill_buf_q};
                    fill_buf_d   = '0;
                    fill_cnt_d   = '0;
                    flush_pend_d = 1'b0;
                    state_d      = FILL;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            fill_buf_q   <= '0;
            fill_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_buf_q   <= fill_buf_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    led_sopc_nios2_qsys_oci_dct_frame_reg u_frame_reg (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .load_i       (load),
        .load_frame_i (load_frame),
        .ready_i      (frm_ready),
        .valid_o      (frm_valid),
        .frame_o      (frame),
        .free_o       (slot_free)
    );

    assign dct_buffer = frame.buffer;
    assign dct_count  = frame.count;

endmodule

// File: tb/tb_led_sopc_nios2_qsys_oci_dct_packer.sv
// tb/tb_led_sopc_nios2_qsys_oci_dct_packer.sv - self-checking bench for the DCT packer
module tb_led_sopc_nios2_qsys_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'd0;
    logic        atom_ready;
    logic        test_ending = 1'b0;
    logic        test_has_ended = 1'b0;
    logic        frm_valid;
    logic        frm_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_done;

    int total = 0;
    int bad = 0;

    led_sopc_nios2_qsys_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .atom_ready     (atom_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_done       (dct_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [1:0]  ad;
        logic        te;
        logic        fr;
        logic        e_ar;
        logic        e_fv;
        logic        chk_data;
        logic [3:0]  e_cnt;
        logic [29:0] e_buf;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic av, logic [1:0] ad, logic te, logic fr, logic ear,
                                logic efv, logic cd, logic [3:0] ec, logic [29:0] eb);
        vec_t v;
        v.av = av; v.ad = ad; v.te = te; v.fr = fr;
        v.e_ar = ear; v.e_fv = efv; v.chk_data = cd; v.e_cnt = ec; v.e_buf = eb;
        return v;
    endfunction

    // Reference packing: each new atom shifts in at the bottom.
    function automatic logic [29:0] pack_mod4(int first, int n);
        logic [29:0] b = '0;
        for (int k = first; k < first + n; k++) begin
            b = {b[27:0], 2'(k % 4)};
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " atom_ready"}, 32'(atom_ready), 32'd1);
        chk({tag, " frm_valid"}, 32'(frm_valid), 32'd0);
        chk({tag, " dct_count"}, 32'(dct_count), 32'd0);
        chk({tag, " dct_buffer"}, 32'(dct_buffer), 32'd0);
        chk({tag, " dct_done"}, 32'(dct_done), 32'd0);
    endtask

    // Offers atoms k%4 (k counting from 0) until n are accepted, within a cycle budget.
    task automatic feed_mod4(input int n, input int budget, output int accepted);
        logic took;
        accepted = 0;
        for (int cyc = 0; cyc < budget && accepted < n; cyc++) begin
            atom_valid = 1'b1;
            atom_data = 2'(accepted % 4);
            took = atom_ready;
            step();
            if (took) accepted++;
        end
        atom_valid = 1'b0;
    endtask

    initial begin
        logic [29:0] exp1, exp2;
        int acc;
        logic took;

        // table: 15 cycling atoms, idle, 5 atoms with flush on the last, empty flush
        for (int i = 0; i < 15; i++) begin
            vecs[i] = mk(1'b1, 2'((i % 3) + 1), 1'b0, 1'b1, 1'b1, (i == 14), 1'b1,
                         (i == 14) ? 4'd15 : 4'd0, (i == 14) ? 30'h1B6DB6DB : 30'h0);
        end
        vecs[15] = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[16] = mk(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[17] = mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[18] = mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[19] = mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[20] = mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 30'h31B);
        vecs[21] = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[22] = mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);
        vecs[23] = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0);

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            atom_valid = vecs[i].av;
            atom_data = vecs[i].ad;
            test_ending = vecs[i].te;
            frm_ready = vecs[i].fr;
            step();
            chk($sformatf("vec%0d atom_ready", i), 32'(atom_ready), 32'(vecs[i].e_ar));
            chk($sformatf("vec%0d frm_valid", i), 32'(frm_valid), 32'(vecs[i].e_fv));
            chk($sformatf("vec%0d dct_done", i), 32'(dct_done), 32'd0);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d dct_count", i), 32'(dct_count), 32'(vecs[i].e_cnt));
                chk($sformatf("vec%0d dct_buffer", i), 32'(dct_buffer), 32'(vecs[i].e_buf));
            end
        end
        atom_valid = 1'b0;
        test_ending = 1'b0;

        // full and flush in the same cycle -> exactly one frame of 15
        frm_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1;
            atom_data = (i == 14) ? 2'b01 : 2'b10;
            test_ending = (i == 14);
            step();
        end
        atom_valid = 1'b0;
        test_ending = 1'b0;
        chk("fullflush frm_valid", 32'(frm_valid), 32'd1);
        chk("fullflush dct_count", 32'(dct_count), 32'd15);
        chk("fullflush dct_buffer", 32'(dct_buffer), 32'h2AAAAAA9);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fullflush extra%0d", i), 32'(frm_valid), 32'd0);
        end

        // 30 atoms with consumer stalled, release at cycle 40
        exp1 = pack_mod4(0, 15);
        exp2 = pack_mod4(15, 15);
        frm_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            atom_valid = (acc < 30);
            atom_data = 2'(acc % 4);
            took = atom_valid && atom_ready;
            step();
            if (took) acc++;
            if (acc >= 15) begin
                chk($sformatf("stall c%0d frm_valid", cyc), 32'(frm_valid), 32'd1);
                chk($sformatf("stall c%0d dct_buffer", cyc), 32'(dct_buffer), 32'(exp1));
                chk($sformatf("stall c%0d dct_count", cyc), 32'(dct_count), 32'd15);
            end
        end
        atom_valid = 1'b0;
        chk("stall accepted", 32'(acc), 32'd30);
        chk("stall hold atom_ready", 32'(atom_ready), 32'd0);
        frm_ready = 1'b1;
        step();
        chk("release frm_valid", 32'(frm_valid), 32'd1);
        chk("release dct_buffer", 32'(dct_buffer), 32'(exp2));
        chk("release dct_count", 32'(dct_count), 32'd15);
        chk("release atom_ready", 32'(atom_ready), 32'd1);
        step();
        chk("release drained", 32'(frm_valid), 32'd0);

        // reset mid-fill
        feed_mod4(5, 10, acc);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst fill");
        @(negedge clk);
        reset_n = 1'b1;
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        chk("rst fill no frame", 32'(frm_valid), 32'd0);
        step();
        chk("rst fill no frame2", 32'(frm_valid), 32'd0);

        // reset mid-HOLD
        frm_ready = 1'b0;
        feed_mod4(30, 40, acc);
        chk("rst hold in HOLD", 32'(atom_ready), 32'd0);
        chk("rst hold frame", 32'(frm_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst hold");
        @(negedge clk);
        reset_n = 1'b1;
        frm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst hold no frame%0d", i), 32'(frm_valid), 32'd0);
        end

        // end of session with a frame still pending
        frm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'(i + 1);
            test_ending = (i == 2);
            step();
        end
        atom_valid = 1'b0;
        test_ending = 1'b0;
        chk("end frame count", 32'(dct_count), 32'd3);
        chk("end frame buffer", 32'(dct_buffer), 32'h1B);
        test_has_ended = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("end pending done%0d", i), 32'(dct_done), 32'd0);
            chk($sformatf("end pending valid%0d", i), 32'(frm_valid), 32'd1);
        end
        frm_ready = 1'b1;
        step();
        frm_ready = 1'b0;
        chk("end accepted valid", 32'(frm_valid), 32'd0);
        chk("end accepted done", 32'(dct_done), 32'd0);
        step();
        chk("end done", 32'(dct_done), 32'd1);
        chk("end atom_ready", 32'(atom_ready), 32'd0);
        atom_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("done stays ready%0d", i), 32'(atom_ready), 32'd0);
            chk($sformatf("done stays done%0d", i), 32'(dct_done), 32'd1);
            chk($sformatf("done no frame%0d", i), 32'(frm_valid), 32'd0);
        end
        atom_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
